mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the CPU fetch (I) and load/store (D) requesters.
// D has priority, but I is forced through after MAX_D_STREAK back-to-back D grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic [1:0]        err_code
);

    // state | meaning
    // IDLE  | arbitrate between i_req and d_req
    // BUS   | memory transaction outstanding, timeout running
    // DONE  | one-cycle ack (and err) to the granted requester
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    state_t        state;
    logic [SW-1:0] streak;
    logic [7:0]    tcnt;
    logic          gnt_d;

    logic streak_full;
    logic grant_d;
    logic grant_i;
    logic be_ok;
    logic i_bad;
    logic d_bad;

    always_comb begin
        streak_full = (streak == SW'(MAX_D_STREAK));
        grant_d     = d_req && !(i_req && streak_full);
        grant_i     = i_req && !grant_d;
        case (d_be)
            4'b1111, 4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok = 1'b1;
            default:                                     be_ok = 1'b0;
        endcase
        i_bad = (i_addr[1:0] != 2'b00);
        d_bad = !be_ok || ((d_be == 4'b1111) && (d_addr[1:0] != 2'b00));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            tcnt      <= '0;
            gnt_d     <= 1'b0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_code  <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        gnt_d <= grant_d;
                        if (grant_d && i_req) begin
                            if (!streak_full)
                                streak <= streak + 1'b1;
                        end else begin
                            streak <= '0;
                        end
                        // Misaligned requests never reach memory; they complete with an error.
                        if (grant_d ? d_bad : i_bad) begin
                            state    <= DONE;
                            err      <= 1'b1;
                            err_code <= grant_d ? 2'b10 : 2'b01;
                            if (grant_d) begin
                                d_ack   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                i_ack   <= 1'b1;
                                i_rdata <= '0;
                            end
                        end else begin
                            state     <= BUS;
                            mem_req   <= 1'b1;
                            tcnt      <= 8'(TIMEOUT - 1);
                            mem_addr  <= grant_d ? d_addr : i_addr;
                            mem_we    <= grant_d && d_we;
                            mem_be    <= grant_d ? d_be : 4'b1111;
                            mem_wdata <= grant_d ? d_wdata : '0;
                        end
                    end
                end
                BUS: begin
                    if (mem_ack || (tcnt == 8'd0)) begin
                        mem_req <= 1'b0;
                        state   <= DONE;
                        if (gnt_d) begin
                            d_ack   <= 1'b1;
                            d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        if (!mem_ack) begin
                            err      <= 1'b1;
                            err_code <= 2'b11;
                        end
                    end else begin
                        tcnt <= tcnt - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention, alignment errors, timeout, reset.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err;
    logic [1:0]  err_code;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(32), .MAX_D_STREAK(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for mem_req, snapshot the request, ack after lat cycles; returns at the negedge where ack is visible.
    task automatic serve(input int lat, input logic [31:0] rd,
                         output logic [31:0] a, output logic w,
                         output logic [3:0] b, output logic [31:0] wd);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_seen", mem_req, 1);
        a  = mem_addr;
        w  = mem_we;
        b  = mem_be;
        wd = mem_wdata;
        repeat (lat) @(negedge clk);
        mem_rdata = rd;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // Both requesters pending for n grants; bit k of exp_i set means grant k must go to I.
    task automatic contend(input int n, input logic [7:0] exp_i);
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        logic [31:0] wd;
        i_addr = 32'h0000_0100;
        d_addr = 32'h0000_0200;
        d_we   = 1'b0;
        d_be   = 4'hF;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int k = 0; k < n; k++) begin
            serve(0, 32'h5000_0000 + k, a, w, b, wd);
            check($sformatf("grant%0d_addr", k), a, exp_i[k] ? 32'h0000_0100 : 32'h0000_0200);
            check($sformatf("grant%0d_ack", k), {i_ack, d_ack}, exp_i[k] ? 2'b10 : 2'b01);
            if (exp_i[k])
                check($sformatf("grant%0d_irdata", k), i_rdata, 32'h5000_0000 + k);
            else
                check($sformatf("grant%0d_drdata", k), d_rdata, 32'h5000_0000 + k);
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            @(negedge clk);
            i_req = 1'b1;
            d_req = 1'b1;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        logic [31:0] wd;
        int          cnt;
        int          got;
        int          n;

        reset = 1'b1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
        mem_rdata = 0; mem_ack = 0;
        #12;
        check("rst_acks", {i_ack, d_ack, err, mem_req, mem_we}, 0);
        check("rst_data", i_rdata | d_rdata | mem_addr | mem_wdata, 0);
        check("rst_be_code", {mem_be, err_code}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // single fetch
        i_addr = 32'h0000_3000;
        i_req  = 1'b1;
        serve(1, 32'h3C01_0001, a, w, b, wd);
        check("fetch_addr", a, 32'h0000_3000);
        check("fetch_we_be", {w, b}, 5'b0_1111);
        check("fetch_ack", {i_ack, d_ack}, 2'b10);
        check("fetch_rdata", i_rdata, 32'h3C01_0001);
        check("fetch_err", err, 0);
        check("fetch_memreq_drop", mem_req, 0);
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_ack_pulse", i_ack, 0);
        check("fetch_rdata_held", i_rdata, 32'h3C01_0001);

        // byte store
        d_we = 1'b1; d_addr = 32'h0000_0005; d_be = 4'b0010; d_wdata = 32'h0000_AB00;
        d_req = 1'b1;
        serve(0, 32'hDEAD_BEEF, a, w, b, wd);
        check("store_addr", a, 32'h0000_0005);
        check("store_we_be", {w, b}, 5'b1_0010);
        check("store_wdata", wd, 32'h0000_AB00);
        check("store_ack", {i_ack, d_ack}, 2'b01);
        check("store_rdata", d_rdata, 0);
        d_req = 1'b0;
        @(negedge clk);

        // misaligned fetch: no memory access, immediate error completion
        i_addr = 32'h0000_3002;
        i_req  = 1'b1;
        @(negedge clk);
        check("mis_i_memreq", mem_req, 0);
        check("mis_i_ack", {i_ack, d_ack}, 2'b10);
        check("mis_i_err", {err, err_code}, 3'b1_01);
        check("mis_i_rdata", i_rdata, 0);
        i_req = 1'b0;
        @(negedge clk);
        check("mis_i_err_pulse", {err, err_code}, 3'b0_01);

        // bad byte enable
        d_we = 1'b0; d_addr = 32'h0000_0010; d_be = 4'b0011;
        d_req = 1'b1;
        @(negedge clk);
        check("bad_be_ack", {i_ack, d_ack, mem_req}, 3'b010);
        check("bad_be_err", {err, err_code}, 3'b1_10);
        d_req = 1'b0;
        @(negedge clk);

        // word access on a half-word address
        d_addr = 32'h0000_0012; d_be = 4'hF;
        d_req = 1'b1;
        @(negedge clk);
        check("mis_d_ack", {i_ack, d_ack, mem_req}, 3'b010);
        check("mis_d_err", {err, err_code}, 3'b1_10);
        d_req = 1'b0;
        @(negedge clk);

        // good fetch leaves err_code holding the last error
        i_addr = 32'h0000_3004;
        i_req  = 1'b1;
        serve(0, 32'h1234_5678, a, w, b, wd);
        check("fetch2_rdata", {i_ack, i_rdata}, {1'b1, 32'h1234_5678});
        check("fetch2_code_held", {err, err_code}, 3'b0_10);
        i_req = 1'b0;
        @(negedge clk);

        // stray mem_ack while idle
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack", {i_ack, d_ack, err, mem_req}, 0);
        @(negedge clk);
        check("stray_ack2", {i_ack, d_ack, err, mem_req}, 0);

        // starvation: D,D,D,D,I,D
        contend(6, 8'b0001_0000);

        // timeout on a D load
        d_we = 1'b0; d_addr = 32'h0000_0040; d_be = 4'hF;
        d_req = 1'b1;
        cnt = 0;
        got = 0;
        for (int k = 0; k < 40 && got == 0; k++) begin
            @(negedge clk);
            if (d_ack) got = 1;
            else if (mem_req) cnt++;
        end
        check("to_ack_seen", got, 1);
        check("to_req_cycles", cnt, 16);
        check("to_rdata", d_rdata, 0);
        check("to_err", {err, err_code, mem_req}, 4'b1_11_0);
        d_req = 1'b0;
        @(negedge clk);

        // build streak to 3, start a 4th D, then reset mid-BUS
        contend(3, 8'b0000_0000);
        i_addr = 32'h0000_0100;
        d_addr = 32'h0000_0200;
        i_req  = 1'b1;
        d_req  = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_bus_grant", {mem_req, mem_addr}, {1'b1, 32'h0000_0200});
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        check("rst_async_drop", mem_req, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_noack%0d", k), {i_ack, d_ack, mem_req}, 0);
        end

        // streak restarted from zero: four D before the forced I
        contend(5, 8'b0001_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
